// File: rtl/cpu_pkg.sv
// Shared CPU/memory definitions: word geometry, opcodes, and the responder's
// state, request-source and request-record types.
package cpu_pkg;
  localparam int MEM_AW = 5;
  localparam int MEM_DW = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_e;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_e;

  typedef enum logic [1:0] {PORT_INS = 2'd0, PORT_DA = 2'd1, PORT_LD = 2'd2} mem_port_e;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0, SRC_PEND_INS = 3'd1, SRC_PEND_DA = 3'd2,
    SRC_INS = 3'd3, SRC_DA = 3'd4, SRC_LD = 3'd5
  } mem_src_e;

  typedef struct packed {
    mem_port_e           port;
    logic [MEM_AW-1:0]   addr;
    logic                we;
    logic [MEM_DW-1:0]   wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_array.sv
// Word array with a registered read; a same-edge write to the read address
// is forwarded so the read returns the new value.
module mem_array
  import cpu_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data/load responder: fixed-priority arbitration with a
// one-entry pending slot per CPU port and a fixed access latency.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int AW      = MEM_AW,
  parameter int DW      = MEM_DW,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_en,
  input  logic [AW-1:0] ins_addr,
  output logic [DW-1:0] ins_data,
  output logic          ins_valid,
  input  logic          da_en,
  input  logic          da_we,
  input  logic [AW-1:0] da_addr,
  input  logic [DW-1:0] da_wdata,
  output logic [DW-1:0] da_rdata,
  output logic          da_valid,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ack,
  output logic          busy,
  output logic          overrun
);
  mem_state_e    state_r;
  logic [3:0]    cnt_r;
  mem_req_t      cur_r;
  logic          pend_ins_v_r;
  logic [AW-1:0] pend_ins_addr_r;
  logic          pend_da_v_r;
  mem_req_t      pend_da_r;

  mem_src_e      sel_src;
  mem_req_t      sel_req;
  logic          done_s, start_s;
  logic          ins_cap_s, ins_free_s, da_cap_s, da_free_s;
  logic          mem_we_s;
  logic [AW-1:0] raddr_s;
  logic [DW-1:0] rdata_s;

  always_comb begin
    sel_src = SRC_NONE;
    sel_req = '0;
    if (pend_ins_v_r) begin
      sel_src = SRC_PEND_INS;
      sel_req = '{port: PORT_INS, addr: pend_ins_addr_r, we: 1'b0, wdata: {DW{1'b0}}};
    end else if (pend_da_v_r) begin
      sel_src = SRC_PEND_DA;
      sel_req = pend_da_r;
    end else if (ins_en) begin
      sel_src = SRC_INS;
      sel_req = '{port: PORT_INS, addr: ins_addr, we: 1'b0, wdata: {DW{1'b0}}};
    end else if (da_en) begin
      sel_src = SRC_DA;
      sel_req = '{port: PORT_DA, addr: da_addr, we: da_we, wdata: da_wdata};
    end else if (ld_en) begin
      sel_src = SRC_LD;
      sel_req = '{port: PORT_LD, addr: ld_addr, we: 1'b1, wdata: ld_data};
    end else begin
      sel_src = SRC_NONE;
    end
  end

  assign done_s     = (state_r == BUSY) && (cnt_r == 4'd0);
  assign start_s    = (sel_src != SRC_NONE) && ((state_r == IDLE) || done_s);
  // A fresh strobe not taken this edge parks in its slot; the slot counts as
  // free if its occupant is being launched on this same edge.
  assign ins_cap_s  = ins_en && !(start_s && (sel_src == SRC_INS));
  assign ins_free_s = !pend_ins_v_r || (start_s && (sel_src == SRC_PEND_INS));
  assign da_cap_s   = da_en && !(start_s && (sel_src == SRC_DA));
  assign da_free_s  = !pend_da_v_r || (start_s && (sel_src == SRC_PEND_DA));
  assign mem_we_s   = done_s && cur_r.we && !rst;
  // Reads are issued one edge early so the word is ready at completion.
  assign raddr_s    = start_s ? sel_req.addr : cur_r.addr;

  mem_array #(.AW(AW), .DW(DW)) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (cur_r.addr),
    .wdata (cur_r.wdata),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      cnt_r           <= 4'd0;
      cur_r           <= '0;
      pend_ins_v_r    <= 1'b0;
      pend_ins_addr_r <= {AW{1'b0}};
      pend_da_v_r     <= 1'b0;
      pend_da_r       <= '0;
      ins_data        <= {DW{1'b0}};
      da_rdata        <= {DW{1'b0}};
      ins_valid       <= 1'b0;
      da_valid        <= 1'b0;
      ld_ack          <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
      da_valid  <= 1'b0;
      ld_ack    <= 1'b0;
      if (done_s) begin
        case (cur_r.port)
          PORT_INS: begin
            ins_data  <= rdata_s;
            ins_valid <= 1'b1;
          end
          PORT_DA: begin
            if (!cur_r.we) begin
              da_rdata <= rdata_s;
            end
            da_valid <= 1'b1;
          end
          PORT_LD: ld_ack <= 1'b1;
          default: ld_ack <= 1'b0;
        endcase
      end

      if (start_s) begin
        cur_r   <= sel_req;
        cnt_r   <= 4'(LATENCY - 1);
        state_r <= BUSY;
        busy    <= 1'b1;
      end else if (done_s) begin
        state_r <= IDLE;
        busy    <= 1'b0;
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r - 4'd1;
      end

      if (ins_cap_s) begin
        if (ins_free_s) begin
          pend_ins_v_r    <= 1'b1;
          pend_ins_addr_r <= ins_addr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (start_s && (sel_src == SRC_PEND_INS)) begin
        pend_ins_v_r <= 1'b0;
      end

      if (da_cap_s) begin
        if (da_free_s) begin
          pend_da_v_r <= 1'b1;
          pend_da_r   <= '{port: PORT_DA, addr: da_addr, we: da_we, wdata: da_wdata};
        end else begin
          overrun <= 1'b1;
        end
      end else if (start_s && (sel_src == SRC_PEND_DA)) begin
        pend_da_v_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 2 and 1) share stimulus and
// are checked every cycle against a transaction-level reference model.
module tb_mem_responder;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ins_en, da_en, da_we, ld_en;
  logic [AW-1:0] ins_addr, da_addr, ld_addr;
  logic [DW-1:0] da_wdata, ld_data;
  logic [1:0][DW-1:0] ins_data, da_rdata;
  logic [1:0] ins_valid, da_valid, ld_ack, busy, overrun;

  mem_responder #(.AW(AW), .DW(DW), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .ins_en(ins_en), .ins_addr(ins_addr), .ins_data(ins_data[0]),
    .ins_valid(ins_valid[0]), .da_en(da_en), .da_we(da_we), .da_addr(da_addr),
    .da_wdata(da_wdata), .da_rdata(da_rdata[0]), .da_valid(da_valid[0]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack[0]), .busy(busy[0]),
    .overrun(overrun[0]));

  mem_responder #(.AW(AW), .DW(DW), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .ins_en(ins_en), .ins_addr(ins_addr), .ins_data(ins_data[1]),
    .ins_valid(ins_valid[1]), .da_en(da_en), .da_we(da_we), .da_addr(da_addr),
    .da_wdata(da_wdata), .da_rdata(da_rdata[1]), .da_valid(da_valid[1]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack[1]), .busy(busy[1]),
    .overrun(overrun[1]));

  // Reference model: one in-flight access with an absolute completion time,
  // plus a single waiting request per CPU port.
  int          lat_k [2] = '{2, 1};
  logic [DW-1:0] m_mem [2][32];
  bit          m_busy [2];
  int          m_done [2];
  int          m_port [2];
  logic [AW-1:0] m_addr [2];
  bit          m_we [2];
  logic [DW-1:0] m_wd [2];
  bit          m_pi_v [2];
  logic [AW-1:0] m_pi_a [2];
  bit          m_pd_v [2];
  logic [AW-1:0] m_pd_a [2];
  bit          m_pd_we [2];
  logic [DW-1:0] m_pd_wd [2];
  logic [DW-1:0] e_ins_data [2], e_da_rdata [2];
  bit          e_ins_valid [2], e_da_valid [2], e_ld_ack [2], e_overrun [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic accept(int k, int p, logic [AW-1:0] a, bit we, logic [DW-1:0] wd);
    m_busy[k] = 1'b1;
    m_done[k] = cyc + lat_k[k];
    m_port[k] = p;
    m_addr[k] = a;
    m_we[k]   = we;
    m_wd[k]   = wd;
  endtask

  task automatic model_edge(int k);
    int src;
    if (rst) begin
      m_busy[k] = 1'b0; m_pi_v[k] = 1'b0; m_pd_v[k] = 1'b0;
      e_ins_data[k] = '0; e_da_rdata[k] = '0; e_ins_valid[k] = 1'b0;
      e_da_valid[k] = 1'b0; e_ld_ack[k] = 1'b0; e_overrun[k] = 1'b0;
    end else begin
      e_ins_valid[k] = 1'b0; e_da_valid[k] = 1'b0; e_ld_ack[k] = 1'b0;
      if (m_busy[k] && cyc == m_done[k]) begin
        if (m_port[k] == 0) begin
          e_ins_data[k] = m_mem[k][m_addr[k]]; e_ins_valid[k] = 1'b1;
        end else if (m_port[k] == 1) begin
          if (m_we[k]) m_mem[k][m_addr[k]] = m_wd[k];
          else e_da_rdata[k] = m_mem[k][m_addr[k]];
          e_da_valid[k] = 1'b1;
        end else begin
          m_mem[k][m_addr[k]] = m_wd[k]; e_ld_ack[k] = 1'b1;
        end
        m_busy[k] = 1'b0;
      end
      src = -1;
      if (!m_busy[k]) begin
        if (m_pi_v[k]) src = 0;
        else if (m_pd_v[k]) src = 1;
        else if (ins_en) src = 2;
        else if (da_en) src = 3;
        else if (ld_en) src = 4;
      end
      case (src)
        0: begin accept(k, 0, m_pi_a[k], 1'b0, '0); m_pi_v[k] = 1'b0; end
        1: begin accept(k, 1, m_pd_a[k], m_pd_we[k], m_pd_wd[k]); m_pd_v[k] = 1'b0; end
        2: accept(k, 0, ins_addr, 1'b0, '0);
        3: accept(k, 1, da_addr, da_we, da_wdata);
        4: accept(k, 2, ld_addr, 1'b1, ld_data);
        default: ;
      endcase
      if (ins_en && src != 2) begin
        if (m_pi_v[k]) e_overrun[k] = 1'b1;
        else begin m_pi_v[k] = 1'b1; m_pi_a[k] = ins_addr; end
      end
      if (da_en && src != 3) begin
        if (m_pd_v[k]) e_overrun[k] = 1'b1;
        else begin
          m_pd_v[k] = 1'b1; m_pd_a[k] = da_addr; m_pd_we[k] = da_we; m_pd_wd[k] = da_wdata;
        end
      end
    end
  endtask

  task automatic check(string tag, int k, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[L%0d] cyc=%0d: observed %0h expected %0h", tag, lat_k[k], cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("ins_data", k, ins_data[k], e_ins_data[k]);
      check("ins_valid", k, {7'd0, ins_valid[k]}, {7'd0, e_ins_valid[k]});
      check("da_rdata", k, da_rdata[k], e_da_rdata[k]);
      check("da_valid", k, {7'd0, da_valid[k]}, {7'd0, e_da_valid[k]});
      check("ld_ack", k, {7'd0, ld_ack[k]}, {7'd0, e_ld_ack[k]});
      check("busy", k, {7'd0, busy[k]}, {7'd0, m_busy[k]});
      check("overrun", k, {7'd0, overrun[k]}, {7'd0, e_overrun[k]});
    end
  endtask

  task automatic settle();
    repeat (6) cycle();
  endtask

  task automatic load_word(logic [AW-1:0] a, logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (e_ld_ack[0]) break;
    end
    check("ld_ack_seen", 0, {7'd0, ld_ack[0]}, 8'd1);
    ld_en = 1'b0;
    settle();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; ins_en = 1'b0; da_en = 1'b0; da_we = 1'b0; ld_en = 1'b0;
    ins_addr = '0; da_addr = '0; ld_addr = '0; da_wdata = '0; ld_data = '0;
    cycle(); cycle();
    check("reset_busy", 0, {7'd0, busy[0]}, 8'd0);
    check("reset_ins_data", 0, ins_data[0], 8'd0);
    rst = 1'b0;
    cycle();

    // Directed load of 0xA5 to address 3: ack two edges after acceptance.
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = 8'hA5;
    cycle(); cycle();
    check("ld_ack_early", 0, {7'd0, ld_ack[0]}, 8'd0);
    cycle();
    check("ld_ack_lat2", 0, {7'd0, ld_ack[0]}, 8'd1);
    ld_en = 1'b0;
    settle();

    for (int a = 0; a < 32; a++) begin
      logic [DW-1:0] d;
      d = 8'($urandom);
      if (a == 1) d = 8'h21;
      if (a == 3) d = 8'hA5;
      if (a == 4) d = 8'h7F;
      load_word(5'(a), d);
    end

    // Fetch of address 3.
    ins_en = 1'b1; ins_addr = 5'd3;
    cycle(); ins_en = 1'b0;
    cycle();
    check("fetch_early", 0, {7'd0, ins_valid[0]}, 8'd0);
    cycle();
    check("fetch_valid", 0, {7'd0, ins_valid[0]}, 8'd1);
    check("fetch_data", 0, ins_data[0], 8'hA5);
    settle();

    // Simultaneous ins/da: ins first, da from its pending slot, busy unbroken.
    ins_en = 1'b1; ins_addr = 5'd1; da_en = 1'b1; da_we = 1'b0; da_addr = 5'd4;
    cycle(); ins_en = 1'b0; da_en = 1'b0;
    check("coll_busy1", 0, {7'd0, busy[0]}, 8'd1);
    cycle();
    check("coll_busy2", 0, {7'd0, busy[0]}, 8'd1);
    cycle();
    check("coll_ins_valid", 0, {7'd0, ins_valid[0]}, 8'd1);
    check("coll_ins_data", 0, ins_data[0], 8'h21);
    check("coll_busy3", 0, {7'd0, busy[0]}, 8'd1);
    cycle();
    check("coll_busy4", 0, {7'd0, busy[0]}, 8'd1);
    cycle();
    check("coll_da_valid", 0, {7'd0, da_valid[0]}, 8'd1);
    check("coll_da_data", 0, da_rdata[0], 8'h7F);
    check("coll_busy_fall", 0, {7'd0, busy[0]}, 8'd0);
    settle();

    // Write 0x3C to 9, then read it straight back.
    da_en = 1'b1; da_we = 1'b1; da_addr = 5'd9; da_wdata = 8'h3C;
    cycle(); da_we = 1'b0;
    cycle(); da_en = 1'b0;
    cycle();
    check("wr_valid", 0, {7'd0, da_valid[0]}, 8'd1);
    check("wr_rdata_held", 0, da_rdata[0], 8'h7F);
    cycle(); cycle();
    check("raw_valid", 0, {7'd0, da_valid[0]}, 8'd1);
    check("raw_data", 0, da_rdata[0], 8'h3C);
    settle();

    // Overrun: second data strobe while the slot is still occupied.
    ins_en = 1'b1; ins_addr = 5'd0; da_en = 1'b1; da_addr = 5'd2;
    cycle(); ins_en = 1'b0; da_addr = 5'd5;
    cycle(); da_en = 1'b0;
    check("overrun_set", 0, {7'd0, overrun[0]}, 8'd1);
    settle(); settle();
    check("overrun_sticky", 0, {7'd0, overrun[0]}, 8'd1);

    // Reset one cycle before a write completes.
    da_en = 1'b1; da_we = 1'b1; da_addr = 5'd9; da_wdata = 8'hC3;
    cycle(); da_en = 1'b0; da_we = 1'b0;
    cycle(); rst = 1'b1;
    cycle();
    check("rst_da_valid", 0, {7'd0, da_valid[0]}, 8'd0);
    check("rst_busy", 0, {7'd0, busy[0]}, 8'd0);
    check("rst_overrun", 0, {7'd0, overrun[0]}, 8'd0);
    check("rst_da_rdata", 0, da_rdata[0], 8'd0);
    check("rst_ins_data", 0, ins_data[0], 8'd0);
    rst = 1'b0;
    cycle();
    da_en = 1'b1; da_addr = 5'd9;
    cycle(); da_en = 1'b0;
    cycle(); cycle();
    check("rst_keeps_old", 0, da_rdata[0], 8'h3C);
    settle();

    // LATENCY=1 streaming: four held fetch cycles give four pulses.
    cnt = 0;
    ins_en = 1'b1; ins_addr = 5'd7;
    repeat (4) begin cycle(); cnt += int'(ins_valid[1]); end
    ins_en = 1'b0;
    repeat (3) begin cycle(); cnt += int'(ins_valid[1]); end
    check("l1_pulses", 1, 8'(cnt), 8'd4);
    check("l1_no_overrun", 1, {7'd0, overrun[1]}, 8'd0);
    settle();

    // Randomised traffic on all ports.
    repeat (600) begin
      ins_en   = ($urandom_range(0, 3) == 0);
      ins_addr = 5'($urandom);
      da_en    = ($urandom_range(0, 3) == 0);
      da_we    = $urandom_range(0, 1) == 1;
      da_addr  = 5'($urandom);
      da_wdata = 8'($urandom);
      ld_en    = ($urandom_range(0, 4) == 0);
      ld_addr  = 5'($urandom);
      ld_data  = 8'($urandom);
      cycle();
    end
    ins_en = 1'b0; da_en = 1'b0; ld_en = 1'b0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
